gf180mcu_osu_sc_12t_clkdiv: RTL and testbench

GF180MCU_OSU_SC_12T_CLKDIV -- requirements
Module: gf180mcu_osu_sc_12T_clkdiv

---
 rtl/gf180mcu_osu_sc_12t_clkdiv.sv | 111 +++++++++++
 tb/tb_gf180mcu_osu_sc_12t_clkdiv.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/gf180mcu_osu_sc_12t_clkdiv.sv
// rtl/gf180mcu_osu_sc_12t_clkdiv.sv - glitch-free programmable 50% duty clock divider
//
// Purpose:
//   Divides CLK by 2*(div_q+1). The ratio and the run request are only sampled
//   at the entry edge (leaving IDLE) and at each Y falling edge, so a running
//   half-period is never truncated or stretched. Only reset may cut a phase short.
//
// Ports:
//   CLK    - input, the single clock (rising edge)
//   RN     - input, asynchronous active-low reset
//   EN     - input, run request, sampled at entry and at Y falling edges
//   DIV    - input [WIDTH-1:0], half-period minus one in CLK cycles
//   Y      - output, divided clock, straight from a flop
//   ACTIVE - output, high while the divider is in RUN
//   TICK   - output, high for the one CLK cycle starting at each Y rising edge

module gf180mcu_osu_sc_12t_clkdiv #(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             RN,
  input  logic             EN,
  input  logic [WIDTH-1:0] DIV,
  output logic             Y,
  output logic             ACTIVE,
  output logic             TICK
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic             y_q, y_d;
  logic             tick_q, tick_d;
  logic             active_q, active_d;

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      div_q    <= '0;
      y_q      <= 1'b0;
      tick_q   <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      y_q      <= y_d;
      tick_q   <= tick_d;
      active_q <= active_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    y_d     = y_q;
    tick_d  = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        y_d   = 1'b0;
        if (EN) begin
          // Entry edge: latch the ratio; Y stays low so the first low phase
          // is a full div_q+1 cycles.
          state_d = RUN;
          div_d   = DIV;
        end
      end
      RUN: begin
        if (cnt_q == div_q) begin
          cnt_d = '0;
          if (!y_q) begin
            y_d    = 1'b1;
            tick_d = 1'b1;
          end else begin
            // Falling edge closes a full period: the only place in RUN where
            // a new ratio or a stop request is taken.
            y_d = 1'b0;
            if (EN) begin
              div_d = DIV;
            end else begin
              state_d = IDLE;
            end
          end
        end else begin
          cnt_d = cnt_q + WIDTH'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        y_d     = 1'b0;
      end
    endcase

    active_d = (state_d == RUN);
  end

  assign Y      = y_q;
  assign TICK   = tick_q;
  assign ACTIVE = active_q;

endmodule

// File: tb/tb_gf180mcu_osu_sc_12t_clkdiv.sv
// tb/tb_gf180mcu_osu_sc_12t_clkdiv.sv - scoreboard bench for the clock divider
//
// Purpose:
//   Drives EN/DIV per CLK edge, predicts {ACTIVE,Y,TICK} with a phase-position
//   reference model, queues the prediction and compares it after the edge.
//
// Ports: none (top-level bench).

module tb_gf180mcu_osu_sc_12t_clkdiv;

  localparam int WIDTH = 4;

  logic             clk;
  logic             rn;
  logic             en;
  logic [WIDTH-1:0] div;
  logic             y;
  logic             active;
  logic             tick;

  gf180mcu_osu_sc_12t_clkdiv #(.WIDTH(WIDTH)) dut (
    .CLK    (clk),
    .RN     (rn),
    .EN     (en),
    .DIV    (div),
    .Y      (y),
    .ACTIVE (active),
    .TICK   (tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Expected {ACTIVE, Y, TICK} after each edge.
  logic [2:0] exp_q[$];

  // Reference model: position within the current period since its start edge.
  bit m_run = 0;
  int m_pos = 0;
  int m_h   = 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_edge(input bit e, input int d);
    if (!rn) begin
      m_run = 0;
      m_pos = 0;
    end else if (!m_run) begin
      if (e) begin
        m_run = 1;
        m_pos = 0;
        m_h   = d + 1;
      end
    end else begin
      m_pos++;
      if (m_pos == 2 * m_h) begin
        if (e) begin
          m_pos = 0;
          m_h   = d + 1;
        end else begin
          m_run = 0;
          m_pos = 0;
        end
      end
    end
  endtask

  task automatic step(input bit e, input int d);
    logic [2:0] got;
    logic [2:0] exp;
    en  = e;
    div = d[WIDTH-1:0];
    model_edge(e, d);
    exp_q.push_back({m_run, m_run && (m_pos >= m_h), m_run && (m_pos == m_h)});
    @(posedge clk);
    #1;
    got = {active, y, tick};
    if (exp_q.size() == 0) begin
      chk("queue_empty", 32'd0, 32'd1);
    end else begin
      exp = exp_q.pop_front();
      chk("active", {31'd0, got[2]}, {31'd0, exp[2]});
      chk("y",      {31'd0, got[1]}, {31'd0, exp[1]});
      chk("tick",   {31'd0, got[0]}, {31'd0, exp[0]});
    end
  endtask

  task automatic run(input bit e, input int d, input int n);
    for (int i = 0; i < n; i++) step(e, d);
  endtask

  initial begin
    rn  = 1'b0;
    en  = 1'b1;
    div = '0;

    // Reset held with EN=1 and CLK running: everything stays low.
    run(1, 3, 5);
    #2 rn = 1'b1;

    // DIV=2: rise E3, fall E6, rise E9; then stop.
    run(1, 2, 13);
    run(0, 2, 8);

    // DIV 2->5 at E4: fall still at E6, next rise E12, fall E18.
    run(1, 2, 4);
    run(1, 5, 20);
    run(0, 5, 14);

    // EN low from E4: stop at E6, re-entry at E8, rise E11.
    run(1, 2, 4);
    run(0, 2, 4);
    run(1, 2, 8);
    run(0, 2, 8);

    // EN glitch between sample points has no effect.
    run(1, 2, 2);
    run(0, 2, 2);
    run(1, 2, 10);
    run(0, 2, 8);

    // Extremes of the ratio.
    run(1, 15, 70);
    run(0, 15, 40);
    run(1, 0, 10);
    run(0, 0, 4);

    // Random EN (mostly high) and DIV.
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 3) != 0), int'($urandom_range(0, 7)));
    end
    run(0, 0, 40);

    // Reset while Y is high: outputs drop without a CLK edge.
    run(1, 3, 6);
    chk("pre_reset_y", {31'd0, y}, 32'd1);
    #2 rn = 1'b0;
    #1;
    chk("async_y",      {31'd0, y},      32'd0);
    chk("async_active", {31'd0, active}, 32'd0);
    chk("async_tick",   {31'd0, tick},   32'd0);
    run(1, 3, 3);
    #2 rn = 1'b1;
    run(1, 1, 12);
    run(0, 1, 6);

    chk("queue_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
